// File: rtl/ddco_sweep_pkg.sv
// ---------------------------------------------------------------------------
// ddco_sweep_pkg
//   Shared types for the exhaustive gate sweep checker and its golden
//   reference gate. Imported by gate_sweep_checker and ref_gate.
//   Revision: 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

package ddco_sweep_pkg;

  // Reference reduction applied across all DUT inputs.
  typedef enum logic [1:0] {
    MODE_AND  = 2'd0,
    MODE_OR   = 2'd1,
    MODE_XOR  = 2'd2,
    MODE_NAND = 2'd3
  } gate_mode_e;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } sweep_state_e;

endpackage : ddco_sweep_pkg

`default_nettype wire

// File: rtl/gate_sweep_checker_ref_gate.sv
// ---------------------------------------------------------------------------
// ref_gate
//   Golden N_IN-input combinational reduction gate (AND/OR/XOR/NAND).
//   Ports:
//     vec_i  [N_IN-1:0]  input vector
//     mode_i [1:0]       reduction select (gate_mode_e encoding)
//     exp_o              expected gate output
//   Revision: 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module ref_gate
  import ddco_sweep_pkg::*;
#(
  parameter int N_IN = 2
) (
  input  logic [N_IN-1:0] vec_i,
  input  logic [1:0]      mode_i,
  output logic            exp_o
);

  always_comb begin
    exp_o = 1'b0;
    case (mode_i)
      MODE_AND:  exp_o = &vec_i;
      MODE_OR:   exp_o = |vec_i;
      MODE_XOR:  exp_o = ^vec_i;
      MODE_NAND: exp_o = ~&vec_i;
      default:   exp_o = 1'b0;
    endcase
  end

endmodule : ref_gate

`default_nettype wire

// File: rtl/gate_sweep_checker.sv
// ---------------------------------------------------------------------------
// gate_sweep_checker
//   Exhaustive stimulus sequencer for a small combinational DUT gate. Walks
//   all 2^N_IN input vectors, holding each for DWELL cycles, samples the DUT
//   response in the last dwell cycle and compares it against ref_gate.
//   Ports:
//     clk, rst_n               clock, async active-low reset
//     start_i                  begin sweep (honoured in IDLE/DONE only)
//     mode_i [1:0]             reference op, latched at start
//     vec_out_o [N_IN-1:0]     stimulus to DUT
//     dut_resp_i               DUT response (combinational from vec_out_o)
//     busy_o, done_o, pass_o   status
//     err_count_o [N_IN:0]     mismatching vector count
//     fail_seen_o              any mismatch recorded
//     first_fail_vec_o         index of first mismatching vector
//   Revision: 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module gate_sweep_checker
  import ddco_sweep_pkg::*;
#(
  parameter int N_IN  = 2,
  parameter int DWELL = 10,
  parameter int CNT_W = $clog2(DWELL + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [1:0]      mode_i,
  output logic [N_IN-1:0] vec_out_o,
  input  logic            dut_resp_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            pass_o,
  output logic [N_IN:0]   err_count_o,
  output logic            fail_seen_o,
  output logic [N_IN-1:0] first_fail_vec_o
);

  localparam logic [N_IN:0]    C_IDX_LAST  = (N_IN+1)'((1 << N_IN) - 1);
  localparam logic [CNT_W-1:0] C_CNT_LAST  = CNT_W'(DWELL - 1);

  sweep_state_e      state_q, state_d;
  gate_mode_e        mode_q, mode_d;
  logic [N_IN:0]     idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [N_IN:0]     err_q, err_d;
  logic              fail_q, fail_d;
  logic [N_IN-1:0]   ffv_q, ffv_d;

  logic              w_exp;
  logic              w_mismatch;
  logic              w_last_dwell;
  logic              w_last_vec;
  logic              w_start_ok;
  logic [N_IN:0]     w_idx_inc;

  ref_gate #(
    .N_IN (N_IN)
  ) u_ref_gate (
    .vec_i  (idx_q[N_IN-1:0]),
    .mode_i (mode_q),
    .exp_o  (w_exp)
  );

  assign w_last_dwell = (cnt_q == C_CNT_LAST);
  assign w_last_vec   = (idx_q == C_IDX_LAST);
  assign w_start_ok   = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign w_idx_inc    = idx_q + 1'b1;

  // Exact-match case: an X/Z response matches neither arm in simulation and
  // therefore lands in the mismatch default.
  always_comb begin
    w_mismatch = 1'b1;
    case ({dut_resp_i, w_exp})
      2'b00, 2'b11: w_mismatch = 1'b0;
      default:      w_mismatch = 1'b1;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (w_start_ok) state_d = ST_DRIVE;
      ST_DRIVE:         if (w_last_dwell && w_last_vec) state_d = ST_FLUSH;
      ST_FLUSH:         if (w_last_dwell) state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next values; all outputs are registered below.
  always_comb begin
    mode_d = mode_q;
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    vec_d  = vec_q;
    err_d  = err_q;
    fail_d = fail_q;
    ffv_d  = ffv_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (w_start_ok) begin
          mode_d = gate_mode_e'(mode_i);
          idx_d  = '0;
          cnt_d  = '0;
          vec_d  = '0;
          err_d  = '0;
          fail_d = 1'b0;
          ffv_d  = '0;
        end
      end
      ST_DRIVE: begin
        cnt_d = cnt_q + 1'b1;
        if (w_last_dwell) begin
          cnt_d = '0;
          if (w_mismatch) begin
            err_d = err_q + 1'b1;
            if (!fail_q) begin
              fail_d = 1'b1;
              ffv_d  = idx_q[N_IN-1:0];
            end
          end
          if (w_last_vec) begin
            vec_d = '0;
          end else begin
            idx_d = w_idx_inc;
            vec_d = w_idx_inc[N_IN-1:0];
          end
        end
      end
      ST_FLUSH: begin
        cnt_d = w_last_dwell ? '0 : cnt_q + 1'b1;
      end
      default: ;
    endcase
    busy_d = (state_d == ST_DRIVE) || (state_d == ST_FLUSH);
    done_d = (state_d == ST_DONE);
    pass_d = done_d && (err_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_AND;
      idx_q  <= '0;
      cnt_q  <= '0;
      vec_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      err_q  <= '0;
      fail_q <= 1'b0;
      ffv_q  <= '0;
    end else begin
      mode_q <= mode_d;
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      vec_q  <= vec_d;
      busy_q <= busy_d;
      done_q <= done_d;
      pass_q <= pass_d;
      err_q  <= err_d;
      fail_q <= fail_d;
      ffv_q  <= ffv_d;
    end
  end

  assign vec_out_o        = vec_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign pass_o           = pass_q;
  assign err_count_o      = err_q;
  assign fail_seen_o      = fail_q;
  assign first_fail_vec_o = ffv_q;

endmodule : gate_sweep_checker

`default_nettype wire

// File: tb/tb_gate_sweep_checker.sv
// ---------------------------------------------------------------------------
// tb_gate_sweep_checker
//   Directed bench for gate_sweep_checker: instance A (N_IN=2, DWELL=10) and
//   instance B (N_IN=3, DWELL=1) driving an emulated gate DUT whose function
//   is chosen independently of the checker mode.
//   Revision: 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_gate_sweep_checker;

  logic       clk;
  logic       rst_n;
  logic       start_a, start_b;
  logic [1:0] mode;
  int         dut_sel;     // 0 AND, 1 OR, 2 XOR, 3 NAND, 4 stuck-at-1

  logic [1:0] vec_a, ffv_a;
  logic [2:0] err_a;
  logic       resp_a, busy_a, done_a, pass_a, fail_a;
  logic [2:0] vec_b, ffv_b;
  logic [3:0] err_b;
  logic       resp_b, busy_b, done_b, pass_b, fail_b;

  int         n_tests;
  int         n_fail;
  logic [7:0] trace [0:255];
  logic       busyt [0:255];
  int         cyc;

  gate_sweep_checker #(.N_IN(2), .DWELL(10)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start_i(start_a), .mode_i(mode),
    .vec_out_o(vec_a), .dut_resp_i(resp_a), .busy_o(busy_a),
    .done_o(done_a), .pass_o(pass_a), .err_count_o(err_a),
    .fail_seen_o(fail_a), .first_fail_vec_o(ffv_a)
  );

  gate_sweep_checker #(.N_IN(3), .DWELL(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start_i(start_b), .mode_i(mode),
    .vec_out_o(vec_b), .dut_resp_i(resp_b), .busy_o(busy_b),
    .done_o(done_b), .pass_o(pass_b), .err_count_o(err_b),
    .fail_seen_o(fail_b), .first_fail_vec_o(ffv_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Emulated DUT gate over the low n bits of v.
  function automatic logic gate_fn(input int sel, input logic [7:0] v, input int n);
    logic a, o, x;
    a = 1'b1; o = 1'b0; x = 1'b0;
    for (int i = 0; i < n; i++) begin
      a = a & v[i];
      o = o | v[i];
      x = x ^ v[i];
    end
    case (sel)
      0: return a;
      1: return o;
      2: return x;
      3: return ~a;
      default: return 1'b1;
    endcase
  endfunction

  always_comb resp_a = gate_fn(dut_sel, {6'd0, vec_a}, 2);
  always_comb resp_b = gate_fn(dut_sel, {5'd0, vec_b}, 3);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one sweep on instance A (b=0) or B (b=1). trace[k] holds vec_out
  // sampled just after the k-th edge following the start-sampling edge.
  // At cycle chg_at the mode input is flipped and start is re-pulsed.
  task automatic run(input bit b, input logic [1:0] m, input int sel,
                     input int chg_at, output int cycles);
    bit seen;
    cycles = -1;
    seen   = 1'b0;
    @(negedge clk);
    mode    = m;
    dut_sel = sel;
    if (b) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
    trace[0] = b ? {5'd0, vec_b} : {6'd0, vec_a};
    busyt[0] = b ? busy_b : busy_a;
    for (int k = 1; k <= 200 && !seen; k++) begin
      @(posedge clk); #1;
      trace[k] = b ? {5'd0, vec_b} : {6'd0, vec_a};
      busyt[k] = b ? busy_b : busy_a;
      if (k == chg_at) begin
        mode = ~m;
        if (b) start_b = 1'b1; else start_a = 1'b1;
      end else begin
        start_a = 1'b0; start_b = 1'b0;
      end
      if (b ? done_b : done_a) begin
        cycles = k;
        seen   = 1'b1;
      end
    end
    if (!seen) check("sweep_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; mode = 2'd0; dut_sel = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_vec",  {30'd0, vec_a}, 32'd0);
    check("rst_busy", {31'd0, busy_a}, 32'd0);
    check("rst_done", {31'd0, done_a}, 32'd0);
    check("rst_pass", {31'd0, pass_a}, 32'd0);
    check("rst_err",  {29'd0, err_a}, 32'd0);
    check("rst_fail", {31'd0, fail_a}, 32'd0);
    check("rst_ffv",  {30'd0, ffv_a}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // AND mode, correct AND DUT
    run(1'b0, 2'd0, 0, -1, cyc);
    check("and_cycles", cyc, 32'd50);
    check("and_v0",   trace[0],  32'd0);
    check("and_v9",   trace[9],  32'd0);
    check("and_v10",  trace[10], 32'd1);
    check("and_v25",  trace[25], 32'd2);
    check("and_v39",  trace[39], 32'd3);
    check("and_v40",  trace[40], 32'd0);
    check("and_busy45", {31'd0, busyt[45]}, 32'd1);
    check("and_pass", {31'd0, pass_a}, 32'd1);
    check("and_err",  {29'd0, err_a}, 32'd0);
    check("and_fail", {31'd0, fail_a}, 32'd0);
    check("and_busy_done", {31'd0, busy_a}, 32'd0);
    repeat (5) @(posedge clk);
    #1;
    check("done_hold", {31'd0, done_a}, 32'd1);
    check("pass_hold", {31'd0, pass_a}, 32'd1);

    // AND mode against an OR DUT: vectors 01 and 10 disagree
    run(1'b0, 2'd0, 1, -1, cyc);
    check("or_cycles", cyc, 32'd50);
    check("or_err",  {29'd0, err_a}, 32'd2);
    check("or_ffv",  {30'd0, ffv_a}, 32'd1);
    check("or_fail", {31'd0, fail_a}, 32'd1);
    check("or_pass", {31'd0, pass_a}, 32'd0);

    // NAND mode against stuck-at-1: only vector 11 fails
    run(1'b0, 2'd3, 4, -1, cyc);
    check("nand_err", {29'd0, err_a}, 32'd1);
    check("nand_ffv", {30'd0, ffv_a}, 32'd3);
    check("nand_pass", {31'd0, pass_a}, 32'd0);

    // XOR sweep with mode flipped and start re-pulsed mid-sweep
    run(1'b0, 2'd2, 2, 5, cyc);
    check("chg_cycles", cyc, 32'd50);
    check("chg_pass", {31'd0, pass_a}, 32'd1);
    check("chg_err",  {29'd0, err_a}, 32'd0);
    check("chg_v20",  trace[20], 32'd2);

    // N_IN=3, DWELL=1, XOR with correct XOR DUT
    run(1'b1, 2'd2, 2, -1, cyc);
    check("b_cycles", cyc, 32'd9);
    for (int k = 0; k < 8; k++) check("b_vec", trace[k], k);
    check("b_flush", trace[8], 32'd0);
    check("b_pass", {31'd0, pass_b}, 32'd1);

    // N_IN=3, DWELL=1, AND mode against XOR DUT: vectors 1,2,4 fail
    run(1'b1, 2'd0, 2, -1, cyc);
    check("b_and_err", {28'd0, err_b}, 32'd3);
    check("b_and_ffv", {29'd0, ffv_b}, 32'd1);
    check("b_and_pass", {31'd0, pass_b}, 32'd0);

    // Async reset at cycle 23 of an A sweep (AND mode, OR DUT)
    @(negedge clk);
    mode = 2'd0; dut_sel = 1; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (22) @(posedge clk);
    #1;
    check("pre_rst_err", {29'd0, err_a}, 32'd1);
    check("pre_rst_vec", {30'd0, vec_a}, 32'd2);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_vec",  {30'd0, vec_a}, 32'd0);
    check("mid_rst_busy", {31'd0, busy_a}, 32'd0);
    check("mid_rst_err",  {29'd0, err_a}, 32'd0);
    check("mid_rst_fail", {31'd0, fail_a}, 32'd0);
    check("mid_rst_done", {31'd0, done_a}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    run(1'b0, 2'd0, 1, -1, cyc);
    check("post_rst_cycles", cyc, 32'd50);
    check("post_rst_err", {29'd0, err_a}, 32'd2);
    check("post_rst_ffv", {30'd0, ffv_a}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_gate_sweep_checker

`default_nettype wire
